// File: rtl/ex.sv
// Execute stage of the RV32IM pipeline: combinational ALU and multiplier,
// plus an iterative restoring divider that stalls the pipeline while it runs.
module ex #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        reg_we_i,
  input  logic [31:0] link_addr_i,
  input  logic        flush_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        stallreq_o
);

  // Operation class encodings
  localparam logic [2:0] SEL_NOP    = 3'b000;
  localparam logic [2:0] SEL_LOGIC  = 3'b001;
  localparam logic [2:0] SEL_SHIFT  = 3'b010;
  localparam logic [2:0] SEL_ARITH  = 3'b100;
  localparam logic [2:0] SEL_JUMP   = 3'b110;
  localparam logic [2:0] SEL_MULDIV = 3'b111;

  // Operation subtype encodings
  localparam logic [7:0] OP_AND    = 8'h24;
  localparam logic [7:0] OP_OR     = 8'h25;
  localparam logic [7:0] OP_XOR    = 8'h26;
  localparam logic [7:0] OP_SLL    = 8'h7C;
  localparam logic [7:0] OP_SRL    = 8'h02;
  localparam logic [7:0] OP_SRA    = 8'h03;
  localparam logic [7:0] OP_ADD    = 8'h20;
  localparam logic [7:0] OP_SUB    = 8'h22;
  localparam logic [7:0] OP_SLT    = 8'h2A;
  localparam logic [7:0] OP_SLTU   = 8'h2B;
  localparam logic [7:0] OP_MUL    = 8'h18;
  localparam logic [7:0] OP_MULH   = 8'h19;
  localparam logic [7:0] OP_MULHSU = 8'h1A;
  localparam logic [7:0] OP_MULHU  = 8'h1B;
  localparam logic [7:0] OP_DIV    = 8'h1C;
  localparam logic [7:0] OP_DIVU   = 8'h1D;
  localparam logic [7:0] OP_REM    = 8'h1E;
  localparam logic [7:0] OP_REMU   = 8'h1F;

  localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic        negQ_q;
  logic        negR_q;

  logic        isDiv;
  logic        isSignedDiv;
  logic        isRem;
  logic        op1Neg;
  logic        op2Neg;
  logic [31:0] op1Abs;
  logic [31:0] op2Abs;
  logic        divByZero;
  logic        divOverflow;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        stepGe;
  logic [31:0] quotStep_d;
  logic [31:0] remStep_d;

  logic        mulSignA;
  logic        mulSignB;
  logic signed [32:0] mulA;
  logic signed [32:0] mulB;
  logic signed [65:0] product;
  logic [4:0]  shamt;
  logic [31:0] sraRes;
  logic [31:0] result;

  assign isDiv = (alusel_i == SEL_MULDIV) &&
                 ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU) ||
                  (aluop_i == OP_REM) || (aluop_i == OP_REMU));
  assign isSignedDiv = (aluop_i == OP_DIV) || (aluop_i == OP_REM);
  assign isRem       = (aluop_i == OP_REM) || (aluop_i == OP_REMU);
  assign op1Neg      = isSignedDiv & s_op1_i[31];
  assign op2Neg      = isSignedDiv & s_op2_i[31];
  assign op1Abs      = op1Neg ? (32'd0 - s_op1_i) : s_op1_i;
  assign op2Abs      = op2Neg ? (32'd0 - s_op2_i) : s_op2_i;
  assign divByZero   = (s_op2_i == 32'd0);
  assign divOverflow = isSignedDiv && (s_op1_i == 32'h8000_0000) &&
                       (s_op2_i == 32'hFFFF_FFFF);

  // One restoring shift-subtract step; the quotient register shifts the
  // dividend out of its top while quotient bits enter at the bottom.
  assign trial      = {rem_q, quot_q[31]};
  assign diff       = trial - {1'b0, divisor_q};
  assign stepGe     = (trial >= {1'b0, divisor_q});
  assign remStep_d  = stepGe ? diff[31:0] : trial[31:0];
  assign quotStep_d = {quot_q[30:0], stepGe};

  assign stallreq_o = ~rst & isDiv & (state_q != DONE);

  // Divider FSM: accept/special-case in IDLE, iterate in BUSY, present in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      quot_q    <= 32'd0;
      rem_q     <= 32'd0;
      divisor_q <= 32'd0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (isDiv) begin
            if (divByZero) begin
              quot_q  <= 32'hFFFF_FFFF;
              rem_q   <= s_op1_i;
              state_q <= DONE;
            end else if (divOverflow) begin
              quot_q  <= 32'h8000_0000;
              rem_q   <= 32'd0;
              state_q <= DONE;
            end else begin
              quot_q    <= op1Abs;
              rem_q     <= 32'd0;
              divisor_q <= op2Abs;
              negQ_q    <= op1Neg ^ op2Neg;
              negR_q    <= op1Neg;
              cnt_q     <= 6'd0;
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == LAST_STEP) begin
            quot_q  <= negQ_q ? (32'd0 - quotStep_d) : quotStep_d;
            rem_q   <= negR_q ? (32'd0 - remStep_d) : remStep_d;
            state_q <= DONE;
          end else begin
            quot_q <= quotStep_d;
            rem_q  <= remStep_d;
            cnt_q  <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mulSignA = (aluop_i == OP_MUL) || (aluop_i == OP_MULH) || (aluop_i == OP_MULHSU);
  assign mulSignB = (aluop_i == OP_MUL) || (aluop_i == OP_MULH);
  assign mulA     = {mulSignA & s_op1_i[31], s_op1_i};
  assign mulB     = {mulSignB & s_op2_i[31], s_op2_i};
  assign product  = mulA * mulB;
  assign shamt    = s_op2_i[4:0];
  assign sraRes   = 32'($signed(s_op1_i) >>> shamt);

  // Result mux across operation classes; unknown subtypes yield zero
  always_comb begin
    result = 32'd0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  result = s_op1_i & s_op2_i;
          OP_OR:   result = s_op1_i | s_op2_i;
          OP_XOR:  result = s_op1_i ^ s_op2_i;
          default: result = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result = s_op1_i << shamt;
          OP_SRL:  result = s_op1_i >> shamt;
          OP_SRA:  result = sraRes;
          default: result = 32'd0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADD:  result = s_op1_i + s_op2_i;
          OP_SUB:  result = s_op1_i - s_op2_i;
          OP_SLT:  result = {31'd0, $signed(s_op1_i) < $signed(s_op2_i)};
          OP_SLTU: result = {31'd0, s_op1_i < s_op2_i};
          default: result = 32'd0;
        endcase
      end
      SEL_JUMP: result = link_addr_i;
      SEL_MULDIV: begin
        case (aluop_i)
          OP_MUL:    result = product[31:0];
          OP_MULH,
          OP_MULHSU,
          OP_MULHU:  result = product[63:32];
          OP_DIV,
          OP_DIVU,
          OP_REM,
          OP_REMU: begin
            if (state_q == DONE) begin
              result = isRem ? rem_q : quot_q;
            end
          end
          default:   result = 32'd0;
        endcase
      end
      default: result = 32'd0;
    endcase
  end

  // Writeback outputs; everything is held at zero while in reset
  always_comb begin
    reg_wdata_o = 32'd0;
    reg_waddr_o = 5'd0;
    reg_we_o    = 1'b0;
    if (!rst) begin
      reg_wdata_o = result;
      reg_waddr_o = reg_waddr_i;
      reg_we_o    = reg_we_i & ~stallreq_o & (reg_waddr_i != 5'd0);
    end
  end

endmodule
